// File: rtl/bram_arbiter.sv
// Shares one single-port BRAM (1-cycle read latency) between instruction fetch and load/store.
// LS has priority; a starvation counter forces IF through after STARVE_LIMIT LS grants.
module bram_arbiter #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,

    input  logic              if_req_valid_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_req_ready_o,
    output logic              if_rsp_valid_o,
    output logic [31:0]       if_rsp_data_o,

    input  logic              ls_req_valid_i,
    input  logic [ADDR_W-1:0] ls_addr_i,
    input  logic [3:0]        ls_we_i,
    input  logic [31:0]       ls_wdata_i,
    output logic              ls_req_ready_o,
    output logic              ls_rsp_valid_o,
    output logic [31:0]       ls_rsp_data_o,

    output logic              ram_en_o,
    output logic [3:0]        ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i
);

    typedef enum logic [1:0] {OwnNone, OwnIf, OwnLsRd, OwnLsWr} owner_e;

    localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    owner_e     owner_q, owner_d;
    logic       grant_if, grant_ls;

    // Grants are gated by reset so nothing reaches the BRAM while held in reset.
    always_comb begin
        grant_if = 1'b0;
        grant_ls = 1'b0;
        if (rst_ni) begin
            if (ls_req_valid_i && if_req_valid_i) begin
                if (starve_cnt_q == Limit) grant_if = 1'b1;
                else                       grant_ls = 1'b1;
            end else if (ls_req_valid_i) begin
                grant_ls = 1'b1;
            end else if (if_req_valid_i) begin
                grant_if = 1'b1;
            end
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!if_req_valid_i || grant_if) begin
            starve_cnt_d = 4'd0;
        end else if (grant_ls && (starve_cnt_q != Limit)) begin
            starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end

    always_comb begin
        owner_d = OwnNone;
        if (grant_if)                 owner_d = OwnIf;
        else if (grant_ls)            owner_d = (ls_we_i != 4'd0) ? OwnLsWr : OwnLsRd;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= 4'd0;
            owner_q      <= OwnNone;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
        end
    end

    always_comb begin
        ram_en_o    = grant_if | grant_ls;
        ram_we_o    = 4'd0;
        ram_addr_o  = '0;
        ram_wdata_o = 32'd0;
        if (grant_ls) begin
            ram_we_o    = ls_we_i;
            ram_addr_o  = ls_addr_i;
            ram_wdata_o = ls_wdata_i;
        end else if (grant_if) begin
            ram_addr_o  = if_addr_i;
        end
    end

    assign if_req_ready_o = grant_if;
    assign ls_req_ready_o = grant_ls;

    // Responses are steered purely by the owner captured on the previous edge.
    assign if_rsp_valid_o = (owner_q == OwnIf);
    assign if_rsp_data_o  = (owner_q == OwnIf) ? ram_rdata_i : 32'd0;
    assign ls_rsp_valid_o = (owner_q == OwnLsRd) || (owner_q == OwnLsWr);
    assign ls_rsp_data_o  = (owner_q == OwnLsRd) ? ram_rdata_i : 32'd0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: grant priority, starvation guard, response routing, reset.
// A small behavioural BRAM model supplies read data one cycle after each read enable.
module tb_bram_arbiter;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        if_req_valid, if_req_ready, if_rsp_valid;
    logic [31:0] if_addr, if_rsp_data;
    logic        ls_req_valid, ls_req_ready, ls_rsp_valid;
    logic [31:0] ls_addr, ls_wdata, ls_rsp_data;
    logic [3:0]  ls_we;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    int checks = 0;
    int errors = 0;

    bram_arbiter #(
        .ADDR_W       (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .if_req_valid_i (if_req_valid),
        .if_addr_i      (if_addr),
        .if_req_ready_o (if_req_ready),
        .if_rsp_valid_o (if_rsp_valid),
        .if_rsp_data_o  (if_rsp_data),
        .ls_req_valid_i (ls_req_valid),
        .ls_addr_i      (ls_addr),
        .ls_we_i        (ls_we),
        .ls_wdata_i     (ls_wdata),
        .ls_req_ready_o (ls_req_ready),
        .ls_rsp_valid_o (ls_rsp_valid),
        .ls_rsp_data_o  (ls_rsp_data),
        .ram_en_o       (ram_en),
        .ram_we_o       (ram_we),
        .ram_addr_o     (ram_addr),
        .ram_wdata_o    (ram_wdata),
        .ram_rdata_i    (ram_rdata)
    );

    always #5 clk = ~clk;

    // BRAM model: word i preloads to 0xC0DE0000|i, except 0x10 which holds 0xDEADBEEF.
    logic [31:0] mem [64];
    logic        loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
            mem[4] <= 32'hDEAD_BEEF;
            loaded <= 1'b1;
        end else if (ram_en) begin
            if (ram_we == 4'd0) begin
                ram_rdata <= mem[ram_addr[7:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (ram_we[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ifv_t [8] = '{1, 1, 0, 1, 1, 1, 1, 1};
        bit exp_t [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        bit exp_if;

        rst_ni       = 1'b0;
        if_req_valid = 1'b1;
        if_addr      = 32'h10;
        ls_req_valid = 1'b0;
        ls_addr      = 32'h0;
        ls_we        = 4'h0;
        ls_wdata     = 32'h0;
        ram_rdata    = 32'h0;

        // Reset: IF valid must not leak a grant or a BRAM enable.
        repeat (3) tick();
        check("rst_if_ready", 32'(if_req_ready), 32'd0);
        check("rst_ram_en", 32'(ram_en), 32'd0);
        check("rst_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
        check("rst_ls_rsp_valid", 32'(ls_rsp_valid), 32'd0);
        check("rst_ls_rsp_data", ls_rsp_data, 32'd0);
        if_req_valid = 1'b0;
        @(negedge clk) rst_ni = 1'b1;
        tick();

        // Single IF read of 0x10.
        if_req_valid = 1'b1;
        if_addr      = 32'h10;
        #1;
        check("t1_if_ready", 32'(if_req_ready), 32'd1);
        check("t1_ram_en", 32'(ram_en), 32'd1);
        check("t1_ram_addr", ram_addr, 32'h10);
        check("t1_ram_we", 32'(ram_we), 32'd0);
        tick();
        if_req_valid = 1'b0;
        check("t1_if_rsp_valid", 32'(if_rsp_valid), 32'd1);
        check("t1_if_rsp_data", if_rsp_data, 32'hDEAD_BEEF);
        check("t1_ls_rsp_valid", 32'(ls_rsp_valid), 32'd0);

        // LS write 0x20 then read it back.
        ls_req_valid = 1'b1;
        ls_addr      = 32'h20;
        ls_we        = 4'hF;
        ls_wdata     = 32'h1234_5678;
        #1;
        check("t2_ls_ready_wr", 32'(ls_req_ready), 32'd1);
        check("t2_if_ready_wr", 32'(if_req_ready), 32'd0);
        check("t2_ram_we", 32'(ram_we), 32'hF);
        check("t2_ram_wdata", ram_wdata, 32'h1234_5678);
        tick();
        check("t2_ack_valid", 32'(ls_rsp_valid), 32'd1);
        check("t2_ack_data", ls_rsp_data, 32'd0);
        check("t2_ack_if_valid", 32'(if_rsp_valid), 32'd0);
        ls_we = 4'h0;
        #1;
        check("t2_ls_ready_rd", 32'(ls_req_ready), 32'd1);
        check("t2_ram_we_rd", 32'(ram_we), 32'd0);
        tick();
        ls_req_valid = 1'b0;
        check("t2_rd_valid", 32'(ls_rsp_valid), 32'd1);
        check("t2_rd_data", ls_rsp_data, 32'h1234_5678);
        tick();
        check("t2_idle_ls_valid", 32'(ls_rsp_valid), 32'd0);
        check("t2_idle_ram_en", 32'(ram_en), 32'd0);

        // Both held valid: LS x4 then IF, repeating.
        if_req_valid = 1'b1;
        if_addr      = 32'h10;
        ls_req_valid = 1'b1;
        ls_addr      = 32'h20;
        for (int k = 0; k < 10; k++) begin
            exp_if = ((k % 5) == 4);
            #1;
            check($sformatf("t3_if_ready_%0d", k), 32'(if_req_ready), 32'(exp_if));
            check($sformatf("t3_ls_ready_%0d", k), 32'(ls_req_ready), 32'(!exp_if));
            tick();
            check($sformatf("t3_if_rsp_%0d", k), 32'(if_rsp_valid), 32'(exp_if));
            check($sformatf("t3_ls_rsp_%0d", k), 32'(ls_rsp_valid), 32'(!exp_if));
            check($sformatf("t3_data_%0d", k), exp_if ? if_rsp_data : ls_rsp_data,
                  exp_if ? 32'hDEAD_BEEF : 32'h1234_5678);
        end

        // IF drops after two LS grants: counter clears, IF waits four more.
        for (int k = 0; k < 8; k++) begin
            if_req_valid = ifv_t[k];
            #1;
            check($sformatf("t4_if_ready_%0d", k), 32'(if_req_ready), 32'(exp_t[k]));
            check($sformatf("t4_ls_ready_%0d", k), 32'(ls_req_ready), 32'(!exp_t[k]));
            tick();
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        tick();

        // Alternating single IF / LS reads, one per cycle.
        for (int k = 0; k < 6; k++) begin
            if_req_valid = ((k % 2) == 0);
            ls_req_valid = ((k % 2) == 1);
            if_addr      = 32'h40 + 32'(4 * k);
            ls_addr      = 32'h40 + 32'(4 * k);
            #1;
            check($sformatf("t5_ram_addr_%0d", k), ram_addr, 32'h40 + 32'(4 * k));
            tick();
            if ((k % 2) == 0) begin
                check($sformatf("t5_if_valid_%0d", k), 32'(if_rsp_valid), 32'd1);
                check($sformatf("t5_if_data_%0d", k), if_rsp_data, 32'hC0DE_0000 | 32'(16 + k));
                check($sformatf("t5_ls_valid_%0d", k), 32'(ls_rsp_valid), 32'd0);
                check($sformatf("t5_ls_data_%0d", k), ls_rsp_data, 32'd0);
            end else begin
                check($sformatf("t5_ls_valid_%0d", k), 32'(ls_rsp_valid), 32'd1);
                check($sformatf("t5_ls_data_%0d", k), ls_rsp_data, 32'hC0DE_0000 | 32'(16 + k));
                check($sformatf("t5_if_valid_%0d", k), 32'(if_rsp_valid), 32'd0);
                check($sformatf("t5_if_data_%0d", k), if_rsp_data, 32'd0);
            end
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        tick();

        // Reset right after an IF grant drops the pending response.
        if_req_valid = 1'b1;
        if_addr      = 32'h10;
        #1;
        check("t6_if_ready", 32'(if_req_ready), 32'd1);
        tick();
        rst_ni = 1'b0;
        #1;
        check("t6_rst_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
        check("t6_rst_if_rsp_data", if_rsp_data, 32'd0);
        check("t6_rst_ram_en", 32'(ram_en), 32'd0);
        check("t6_rst_if_ready", 32'(if_req_ready), 32'd0);
        tick();
        check("t6_rst2_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
        check("t6_rst2_ram_en", 32'(ram_en), 32'd0);
        if_req_valid = 1'b0;
        @(negedge clk) rst_ni = 1'b1;
        tick();
        check("t6_post_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
        check("t6_post_ls_rsp_valid", 32'(ls_rsp_valid), 32'd0);

        // Counter restarts at zero after reset.
        if_req_valid = 1'b1;
        ls_req_valid = 1'b1;
        ls_addr      = 32'h20;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t6_cnt_if_ready_%0d", k), 32'(if_req_ready), 32'(k == 4));
            tick();
        end
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
Name: bram_arbiter

Overview:
- Shares one single-port, 1-cycle-read-latency BRAM between two requesters: the instruction fetch port (IF) and the load/store port (LS).
- Sits between the pipeline's fetch and memory stages and the BRAM primitive.
- Grants at most one access per cycle and routes each read response back to the requester that issued it.
- Includes a starvation guard so fetch progresses under sustained LS traffic.

Parameters:
- ADDR_W, 32, width of request and BRAM addresses. Addresses pass through unmodified.
- STARVE_LIMIT, 4, maximum consecutive LS grants while IF is waiting before IF is forced through. Legal range 1..15.

Ports:
- clk_i  input  1  system clock, rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- if_req_valid_i  input  1  IF read request
- if_addr_i  input  ADDR_W  IF read address
- if_req_ready_o  output  1  IF request granted this cycle
- if_rsp_valid_o  output  1  IF read data valid
- if_rsp_data_o  output  32  IF read data
- ls_req_valid_i  input  1  LS request
- ls_addr_i  input  ADDR_W  LS address
- ls_we_i  input  4  LS byte write enables; 0 means read
- ls_wdata_i  input  32  LS write data
- ls_req_ready_o  output  1  LS request granted this cycle
- ls_rsp_valid_o  output  1  LS response (read data or write ack)
- ls_rsp_data_o  output  32  LS read data; 0 for write acks
- ram_en_o  output  1  BRAM enable
- ram_we_o  output  4  BRAM byte write enables
- ram_addr_o  output  ADDR_W  BRAM address
- ram_wdata_o  output  32  BRAM write data
- ram_rdata_i  input  32  BRAM read data, valid one cycle after a read enable

Behaviour:
- Reset (rst_ni low, asynchronous):
  - Clears the starvation counter and the response-owner register (owner = NONE).
  - All response outputs read 0.
  - Grant outputs and BRAM outputs are 0 while in reset.
- Grant is combinational in cycle N:
  - Only LS valid: grant LS.
  - Only IF valid: grant IF.
  - Both valid: grant LS unless starve_cnt == STARVE_LIMIT, in which case grant IF.
  - Neither valid: no grant.
- Ready signals:
  - xx_req_ready_o = 1 only for the granted requester.
  - A request is accepted when valid && ready in the same cycle.
  - A requester must hold address and data stable while valid && !ready.
- BRAM drive:
  - ram_en_o = 1 iff a grant occurs.
  - ram_addr_o, ram_we_o and ram_wdata_o come from the granted requester; ram_we_o is always 0 for IF.
  - With no grant, all BRAM outputs are 0.
- Starvation counter (4 bits, saturating at STARVE_LIMIT):
  - Increments on an LS grant while if_req_valid_i = 1.
  - Clears on an IF grant, or in any cycle with if_req_valid_i = 0.
- Owner register: on a clock edge with a grant, owner <= {IF, LS_RD, LS_WR}; otherwise owner <= NONE.
- Responses in cycle N+1:
  - owner = IF: if_rsp_valid_o = 1 and if_rsp_data_o = ram_rdata_i.
  - owner = LS_RD: ls_rsp_valid_o = 1 and ls_rsp_data_o = ram_rdata_i.
  - owner = LS_WR: ls_rsp_valid_o = 1 and ls_rsp_data_o = 0.
  - All non-owner response data reads 0.
  - Responses cannot be back-pressured; requesters must always accept them.
- Latency and throughput:
  - Request to response is exactly 1 cycle.
  - Throughput is 1 access per cycle; back-to-back grants to the same or alternating requesters produce back-to-back responses.
- Reset mid-operation: the outstanding response is dropped, with no rsp_valid after reset release, and the counter restarts at 0.

Test Plan:
- Reset, then IF valid with addr 0x10 and BRAM preloaded 0x10 = 0xDEADBEEF -> if_req_ready_o = 1 in the same cycle; if_rsp_valid_o = 1 with 0xDEADBEEF on the next cycle; ls_rsp_valid_o stays 0.
- LS write we = 0xF, addr 0x20, data 0x12345678; then LS read 0x20 -> write ack (ls_rsp_valid_o = 1, data 0) at N+1; read response 0x12345678 at N+2.
- IF and LS both held valid continuously with STARVE_LIMIT = 4 -> grant pattern LS, LS, LS, LS, IF, repeating. IF is granted every 5th cycle; counter sequence 1,2,3,4,0.
- IF drops valid after 2 LS grants, then returns -> counter clears, and IF again waits 4 LS grants.
- Alternating single IF and LS reads every cycle -> one response per cycle, each routed to the correct owner with correct data. No cycle has both rsp_valid outputs high.
- Assert rst_ni low on the cycle after an IF grant -> if_rsp_valid_o stays 0 through reset and after release; ram_en_o = 0 during reset.
